calendar_counter: RTL

CALENDAR_COUNTER -- requirements
Module: calendar_counter

---
 rtl/calendar_counter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/calendar_counter.sv
// Calendar day/month/year counter with leap-aware month lengths and a
// multi-cycle validated date load (year reduced mod 400 by repeated subtraction).
module calendar_counter #(
    parameter int YEAR_W    = 14,
    parameter int YEAR_MAX  = 9999,
    parameter int GREGORIAN = 1,
    parameter int RST_DAY   = 1,
    parameter int RST_MONTH = 1,
    parameter int RST_YEAR  = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              load,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              leap,
    output logic [4:0]        dim,
    output logic              busy,
    output logic              load_err,
    output logic              new_month,
    output logic              new_year,
    output logic              year_ovf
);

    typedef enum logic [1:0] {IDLE, REDUCE, CHECK} state_t;

    localparam logic [YEAR_W-1:0] YMAX  = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] Y400  = YEAR_W'(400);
    localparam logic [8:0]        RST_R = 9'(RST_YEAR % 400);

    state_t            state;
    logic [8:0]        r;
    logic              pending;
    logic [4:0]        t_day;
    logic [3:0]        t_month;
    logic [YEAR_W-1:0] t_year;
    logic [YEAR_W-1:0] tmp;
    logic              t_leap;
    logic [4:0]        t_dim;
    logic              t_valid;

    function automatic logic is_leap(input logic [8:0] res, input logic [1:0] ylo);
        if (GREGORIAN != 0)
            return (res[1:0] == 2'd0) && (res != 9'd100) && (res != 9'd200) && (res != 9'd300);
        else
            return ylo == 2'd0;
    endfunction

    function automatic logic [4:0] month_days(input logic [3:0] m, input logic lp);
        case (m)
            4'd2:                      return lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    assign leap    = is_leap(r, year[1:0]);
    assign dim     = month_days(month, leap);

    // In CHECK, tmp holds load_year mod 400, so it serves as the candidate residue.
    assign t_leap  = is_leap(tmp[8:0], t_year[1:0]);
    assign t_dim   = month_days(t_month, t_leap);
    assign t_valid = (t_month >= 4'd1) && (t_month <= 4'd12) &&
                     (t_day >= 5'd1) && (t_day <= t_dim) && (t_year <= YMAX);

    always_ff @(posedge clk) begin
        if (state == IDLE && load) begin
            t_day   <= load_day;
            t_month <= load_month;
            t_year  <= load_year;
            tmp     <= load_year;
        end else if (state == REDUCE && tmp >= Y400) begin
            tmp <= tmp - Y400;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            day       <= 5'(RST_DAY);
            month     <= 4'(RST_MONTH);
            year      <= YEAR_W'(RST_YEAR);
            r         <= RST_R;
            busy      <= 1'b0;
            pending   <= 1'b0;
            load_err  <= 1'b0;
            new_month <= 1'b0;
            new_year  <= 1'b0;
            year_ovf  <= 1'b0;
        end else begin
            load_err  <= 1'b0;
            new_month <= 1'b0;
            new_year  <= 1'b0;
            year_ovf  <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= REDUCE;
                        busy    <= 1'b1;
                        pending <= pending | tick;
                    end else if (tick || pending) begin
                        // A deferred tick and a live tick merge into one advance.
                        pending <= 1'b0;
                        if (day < dim) begin
                            day <= day + 5'd1;
                        end else begin
                            day       <= 5'd1;
                            new_month <= 1'b1;
                            if (month == 4'd12) begin
                                month    <= 4'd1;
                                new_year <= 1'b1;
                                if (year == YMAX) begin
                                    year     <= '0;
                                    r        <= 9'd0;
                                    year_ovf <= 1'b1;
                                end else begin
                                    year <= year + YEAR_W'(1);
                                    r    <= (r == 9'd399) ? 9'd0 : r + 9'd1;
                                end
                            end else begin
                                month <= month + 4'd1;
                            end
                        end
                    end
                end
                REDUCE: begin
                    pending <= pending | tick;
                    if (tmp < Y400)
                        state <= CHECK;
                end
                CHECK: begin
                    pending <= pending | tick;
                    busy    <= 1'b0;
                    state   <= IDLE;
                    if (t_valid) begin
                        day   <= t_day;
                        month <= t_month;
                        year  <= t_year;
                        r     <= tmp[8:0];
                    end else begin
                        load_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
